// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, parity selectors and line idle level.
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_rx_if.sv
// Parallel side of the UART receiver: frame configuration in, received byte and status strobes out.
`timescale 1ns/1ps
interface uart_rx_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
);
    logic [PRESCALE_WIDTH-1:0] PRESCALE;
    logic                      PAR_EN;
    logic                      PAR_TYP;
    logic [DATA_WIDTH-1:0]     P_DATA;
    logic                      DATA_VALID;
    logic                      PAR_ERR;
    logic                      STP_ERR;

    modport master (
        output PRESCALE, PAR_EN, PAR_TYP,
        input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR
    );

    modport slave (
        input  PRESCALE, PAR_EN, PAR_TYP,
        output P_DATA, DATA_VALID, PAR_ERR, STP_ERR
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and 3-sample majority voter around the bit centre.
`timescale 1ns/1ps
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      active,
    input  logic                      rx_s,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      sampled_bit,
    output logic                      sample_done,
    output logic                      bit_end
);

    localparam int W = PRESCALE_WIDTH;

    logic [W-1:0] edge_cnt;
    logic [W-1:0] half;
    logic [W-1:0] pos_lo;
    logic [W-1:0] pos_mid;
    logic [W-1:0] pos_hi;
    logic         samp_a;
    logic         samp_b;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    assign half    = prescale >> 1;
    assign pos_lo  = half - W'(1);
    assign pos_mid = half;
    assign pos_hi  = half + W'(1);

    assign bit_end = active && (edge_cnt == prescale - W'(1));

    // Third sample is taken live so the voted bit lands in the caller's registers at P/2+2.
    assign sample_done = active && (edge_cnt == pos_hi);
    assign sampled_bit = majority3(samp_a, samp_b, rx_s);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
        end else if (!active || bit_end) begin
            edge_cnt <= '0;
        end else begin
            edge_cnt <= edge_cnt + W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (edge_cnt == pos_lo) samp_a <= rx_s;
        if (edge_cnt == pos_mid) samp_b <= rx_s;
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizes RX_IN, walks start/data/parity/stop, and strobes out good bytes or errors.
`timescale 1ns/1ps
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      RX_IN,
    uart_rx_if.slave  bus
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    rx_state_e                 state;
    logic                      rx_sync_p0;
    logic                      rx_s;
    logic [PRESCALE_WIDTH-1:0] prescale_q;
    logic                      par_en_q;
    logic                      par_typ_q;
    logic [BW-1:0]             bit_cnt;
    logic [DATA_WIDTH-1:0]     shift_reg;
    logic                      par_bad;
    logic                      sampled_bit;
    logic                      sample_done;
    logic                      bit_end;
    logic                      par_exp;
    logic [DATA_WIDTH-1:0]     p_data_q;
    logic                      data_valid_q;
    logic                      par_err_q;
    logic                      stp_err_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_sync_p0 <= LINE_IDLE;
            rx_s       <= LINE_IDLE;
        end else begin
            rx_sync_p0 <= RX_IN;
            rx_s       <= rx_sync_p0;
        end
    end

    uart_rx_sampler #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_sampler (
        .CLK         (CLK),
        .RST         (RST),
        .active      (state != IDLE),
        .rx_s        (rx_s),
        .prescale    (prescale_q),
        .sampled_bit (sampled_bit),
        .sample_done (sample_done),
        .bit_end     (bit_end)
    );

    assign par_exp = (^shift_reg) ^ (par_typ_q == PAR_ODD);

    always_ff @(posedge CLK) begin
        if (state == DATA && sample_done) begin
            shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            prescale_q   <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= PAR_EVEN;
            bit_cnt      <= '0;
            par_bad      <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    par_bad <= 1'b0;
                    if (rx_s == 1'b0) begin
                        state      <= START;
                        prescale_q <= bus.PRESCALE;
                        par_en_q   <= bus.PAR_EN;
                        par_typ_q  <= bus.PAR_TYP;
                    end
                end
                START: begin
                    if (sample_done && sampled_bit) begin
                        state <= IDLE;
                    end else if (bit_end) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (sample_done) par_bad <= (sampled_bit != par_exp);
                    if (bit_end) state <= STOP;
                end
                STOP: begin
                    // Resolve at the stop-bit centre so a new start edge can be caught right away.
                    if (sample_done) begin
                        state <= IDLE;
                        if (!par_bad && sampled_bit) begin
                            p_data_q     <= shift_reg;
                            data_valid_q <= 1'b1;
                        end else begin
                            par_err_q <= par_bad;
                            stp_err_q <= ~sampled_bit;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.P_DATA     = p_data_q;
    assign bus.DATA_VALID = data_valid_q;
    assign bus.PAR_ERR    = par_err_q;
    assign bus.STP_ERR    = stp_err_q;

endmodule
